// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - 32-bit load/store sequencer onto two 16-bit async SRAM accesses (option: SRAM_MEM_CTRL_READ_HIT_EN)
module sram_mem_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Final cycle of each half-access; we_n is released here so address/data see a hold cycle.
    // With WAIT_CYCLES=1 the only cycle is also the last, so no write strobe is produced.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         cnt_q;
    logic               op_wr_q;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;

    logic [31:0]        off;
    logic [SRAM_AW-2:0] req_word;
    logic               unused_off_bits;
    logic               req;
    logic               hit;
    logic               start;
    logic               last;
    logic               active;
    logic               half;

    // Byte address relative to the SRAM window; byte-in-word bits are ignored.
    assign off             = address - BASE_ADDR;
    assign req_word        = off[SRAM_AW:2];
    assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

    assign req    = wr_en | rd_en;
    assign last   = (cnt_q == LAST_CNT);
    assign active = (state_q == S_LOW) || (state_q == S_HIGH);
    assign half   = (state_q == S_HIGH);
    assign start  = (state_q == S_IDLE) && req && !hit;

`ifdef SRAM_MEM_CTRL_READ_HIT_EN
    logic               buf_valid_q;
    logic [SRAM_AW-2:0] buf_word_q;
    logic [31:0]        buf_data_q;

    assign hit = (state_q == S_IDLE) && rd_en && !wr_en && buf_valid_q && (buf_word_q == req_word);

    // One-entry read buffer: filled by every completed read, invalidated by any accepted write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= '0;
        end else if (start && wr_en) begin
            buf_valid_q <= 1'b0;
        end else if ((state_q == S_HIGH) && last && !op_wr_q) begin
            buf_valid_q <= 1'b1;
            buf_word_q  <= word_q;
            buf_data_q  <= {sram_dq_in, rdata_q[15:0]};
        end
    end

    assign read_data = hit ? buf_data_q : rdata_q;
`else
    assign hit       = 1'b0;
    assign read_data = rdata_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: requests are only looked at in IDLE; DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOW;
            S_LOW:   if (last)  state_d = S_HIGH;
            S_HIGH:  if (last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Wait counter runs 0..WAIT_CYCLES-1 within each half and is zero elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else if (active && !last) begin
            cnt_q <= cnt_q + 4'd1;
        end else begin
            cnt_q <= 4'd0;
        end
    end

    // Latch the operation at acceptance so inputs may change freely while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            op_wr_q <= wr_en;
            word_q  <= req_word;
            wdata_q <= write_data;
        end
    end

    // Capture each read half on the last cycle of its access window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (!op_wr_q && last) begin
            if (state_q == S_LOW) begin
                rdata_q[15:0] <= sram_dq_in;
            end else if (state_q == S_HIGH) begin
                rdata_q[31:16] <= sram_dq_in;
            end
        end
    end

    // Outputs decoded from state: handshake to the pipeline and the SRAM pin controls.
    always_comb begin
        ready       = ((state_q == S_IDLE) && (!req || hit)) || (state_q == S_DONE);
        freeze      = req && !ready;
        sram_addr   = {word_q, half};
        sram_dq_out = half ? wdata_q[31:16] : wdata_q[15:0];
        sram_dq_oe  = active && op_wr_q;
        sram_we_n   = !(active && op_wr_q && !last);
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - directed self-checking bench for sram_mem_ctrl
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:(1<<18)-1];

    always #5 clk = ~clk;

    sram_mem_ctrl #(
        .WAIT_CYCLES(2),
        .BASE_ADDR  (32'd1024),
        .SRAM_AW    (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .freeze     (freeze),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr];

    task automatic apply_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
    endtask

    task automatic test_reset;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, freeze, sram_dq_oe, sram_we_n} !== 4'b1001) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 1001", {ready, freeze, sram_dq_oe, sram_we_n});
        end
        checks++;
        if (read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", read_data); end
        checks++;
        if (sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin
            errors++; $display("FAIL reset_bus: got addr %h dq %h expected 0 0", sram_addr, sram_dq_out);
        end
        apply_req(1'b1, 1'b0, 32'd1028, 32'h11112222);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({sram_dq_oe, sram_we_n} !== 2'b10) begin
            errors++; $display("FAIL reset_pre_write: got oe/we_n %b expected 10", {sram_dq_oe, sram_we_n});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({sram_dq_oe, sram_we_n} !== 2'b01) begin
            errors++; $display("FAIL reset_mid_ctrl: got oe/we_n %b expected 01", {sram_dq_oe, sram_we_n});
        end
        checks++;
        if (sram_addr !== 18'h0 || sram_dq_out !== 16'h0 || read_data !== 32'h0) begin
            errors++; $display("FAIL reset_mid_bus: got addr %h dq %h rdata %h expected 0 0 0", sram_addr, sram_dq_out, read_data);
        end
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_store;
        bit [0:5] rdy_t = 6'b000001;
        bit [0:5] frz_t = 6'b111110;
        bit [0:5] oe_t  = 6'b011110;
        bit [0:5] wen_t = 6'b101011;
        logic [17:0] ea;
        logic [15:0] ed;
        apply_req(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({ready, freeze, sram_dq_oe, sram_we_n} !== {rdy_t[c], frz_t[c], oe_t[c], wen_t[c]}) begin
                errors++; $display("FAIL store_ctrl c%0d: got %b expected %b", c,
                    {ready, freeze, sram_dq_oe, sram_we_n}, {rdy_t[c], frz_t[c], oe_t[c], wen_t[c]});
            end
            if (oe_t[c]) begin
                ea = (c < 3) ? 18'd2 : 18'd3;
                ed = (c < 3) ? 16'hBEEF : 16'hDEAD;
                checks++;
                if (sram_addr !== ea || sram_dq_out !== ed) begin
                    errors++; $display("FAIL store_bus c%0d: got %h/%h expected %h/%h", c, sram_addr, sram_dq_out, ea, ed);
                end
            end
        end
        wr_en = 1'b0;
        checks++;
        if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
            errors++; $display("FAIL store_mem: got %h %h expected beef dead", mem[2], mem[3]);
        end
    endtask

    task automatic test_load;
        bit [0:5] rdy_t = 6'b000001;
        bit [0:5] frz_t = 6'b111110;
        apply_req(1'b0, 1'b1, 32'd1028, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({ready, freeze, sram_dq_oe, sram_we_n} !== {rdy_t[c], frz_t[c], 1'b0, 1'b1}) begin
                errors++; $display("FAIL load_ctrl c%0d: got %b expected %b", c,
                    {ready, freeze, sram_dq_oe, sram_we_n}, {rdy_t[c], frz_t[c], 1'b0, 1'b1});
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (sram_addr !== ((c == 1) ? 18'd2 : 18'd3)) begin
                    errors++; $display("FAIL load_addr c%0d: got %h expected %h", c, sram_addr, (c == 1) ? 18'd2 : 18'd3);
                end
            end
            if (c == 3) begin
                checks++;
                if (read_data !== 32'h0000BEEF) begin errors++; $display("FAIL load_low_half: got %h expected 0000beef", read_data); end
            end
        end
        checks++;
        if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", read_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_both;
        apply_req(1'b1, 1'b1, 32'd1032, 32'h12345678);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({sram_dq_oe, sram_we_n, sram_addr} !== {1'b1, 1'b0, 18'd4}) begin
                    errors++; $display("FAIL both_write c1: got oe %b we_n %b addr %h expected 1 0 4", sram_dq_oe, sram_we_n, sram_addr);
                end
            end
        end
        checks++;
        if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL both_done: got ready %b rdata %h expected 1 deadbeef", ready, read_data);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (mem[4] !== 16'h5678 || mem[5] !== 16'h1234) begin
            errors++; $display("FAIL both_mem: got %h %h expected 5678 1234", mem[4], mem[5]);
        end
    endtask

    task automatic test_drop;
        bit [0:6] rdy_t = 7'b0000011;
        bit [0:6] frz_t = 7'b1100000;
        apply_req(1'b0, 1'b1, 32'd1032, 32'h0);
        for (int c = 0; c < 7; c++) begin
            if (c == 2) begin
                @(posedge clk);
                #1 rd_en = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({ready, freeze} !== {rdy_t[c], frz_t[c]}) begin
                errors++; $display("FAIL drop_ctrl c%0d: got %b expected %b", c, {ready, freeze}, {rdy_t[c], frz_t[c]});
            end
            if (c == 5) begin
                checks++;
                if (read_data !== 32'h12345678) begin errors++; $display("FAIL drop_data: got %h expected 12345678", read_data); end
            end
        end
        checks++;
        if (sram_addr !== 18'd4) begin errors++; $display("FAIL drop_idle_addr: got %h expected 4", sram_addr); end
    endtask

    task automatic test_back_to_back;
        bit [0:11] rdy_t = 12'b000001000001;
        bit [0:11] frz_t = 12'b111110111110;
        bit [0:11] oe_t  = 12'b011110011110;
        bit [0:11] wen_t = 12'b101011101011;
        apply_req(1'b1, 1'b0, 32'd1036, 32'hAAAA5555);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if ({ready, freeze, sram_dq_oe, sram_we_n} !== {rdy_t[c], frz_t[c], oe_t[c], wen_t[c]}) begin
                errors++; $display("FAIL b2b_ctrl c%0d: got %b expected %b", c,
                    {ready, freeze, sram_dq_oe, sram_we_n}, {rdy_t[c], frz_t[c], oe_t[c], wen_t[c]});
            end
            if (c == 7) begin
                checks++;
                if (sram_addr !== 18'd6 || sram_dq_out !== 16'h5555) begin
                    errors++; $display("FAIL b2b_bus c7: got %h/%h expected 6/5555", sram_addr, sram_dq_out);
                end
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_mid_change;
        apply_req(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                address = 32'd1028; write_data = 32'h0;
            end
            if (c == 3) begin
                checks++;
                if (sram_addr !== 18'd9 || sram_dq_out !== 16'hCAFE) begin
                    errors++; $display("FAIL mid_bus c3: got %h/%h expected 9/cafe", sram_addr, sram_dq_out);
                end
            end
        end
        wr_en = 1'b0;
        checks++;
        if (mem[8] !== 16'hF00D || mem[9] !== 16'hCAFE || mem[2] !== 16'hBEEF) begin
            errors++; $display("FAIL mid_mem: got %h %h %h expected f00d cafe beef", mem[8], mem[9], mem[2]);
        end
    endtask

    task automatic test_read_hit;
        apply_req(1'b0, 1'b1, 32'd1028, 32'h0);
        for (int c = 0; c < 6; c++) @(negedge clk);
        rd_en = 1'b0;
        apply_req(1'b0, 1'b1, 32'd1028, 32'h0);
        @(negedge clk);
`ifdef SRAM_MEM_CTRL_READ_HIT_EN
        checks++;
        if ({ready, freeze} !== 2'b10 || read_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hit_c0: got rdy/frz %b rdata %h expected 10 deadbeef", {ready, freeze}, read_data);
        end
        rd_en = 1'b0;
        apply_req(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
        for (int c = 0; c < 6; c++) @(negedge clk);
        wr_en = 1'b0;
        apply_req(1'b0, 1'b1, 32'd1028, 32'h0);
        @(negedge clk);
`endif
        checks++;
        if ({ready, freeze} !== 2'b01) begin errors++; $display("FAIL reload_c0: got %b expected 01", {ready, freeze}); end
        for (int c = 1; c < 6; c++) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reload_c5: got ready %b rdata %h expected 1 deadbeef", ready, read_data);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_both();
        test_drop();
        test_back_to_back();
        test_mid_change();
        test_read_hit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
